pio_irq_servicer: RTL and testbench



---
 rtl/pio_irq_pkg.sv | 26 ++
 rtl/pio_irq_servicer.sv | 187 ++++++++++++++++++
 tb/tb_pio_irq_servicer.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pio_irq_pkg.sv
// Purpose: shared types and constants for the PIO interrupt servicer.
//   state_t  - servicer sequencing states
//   PIO_*    - register offsets of the edge-capturing input PIO
package pio_irq_pkg;

   localparam int unsigned ADDR_W = 2;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned SPUR_W = 8;

   localparam logic [ADDR_W-1:0] PIO_DATA = 2'd0;
   localparam logic [ADDR_W-1:0] PIO_MASK = 2'd2;
   localparam logic [ADDR_W-1:0] PIO_EDGE = 2'd3;

   typedef enum logic [3:0] {
      ST_INIT_MASK,
      ST_INIT_CLR,
      ST_IDLE,
      ST_RD_EDGE,
      ST_RD_EDGE_W,
      ST_CLR_EDGE,
      ST_RD_LVL,
      ST_RD_LVL_W,
      ST_EMIT
   } state_t;

endpackage

// File: rtl/pio_irq_servicer.sv
// Purpose: Avalon-MM initiator that services an edge-capturing 1-bit input
// PIO without CPU help: programs the mask and clears stale captures after
// reset, then on each irq reads/clears the edge capture, reads the pin level
// and offers one event per serviced interrupt on a valid/ready stream.
// Ports:
//   clk, reset_n                  clock, async active-low reset
//   avm_address/chipselect/
//   avm_write_n/avm_writedata     PIO register access (one cycle each)
//   avm_readdata                  PIO read data, fixed latency 1
//   irq                           PIO interrupt
//   evt_valid/evt_ready/evt_level event stream to downstream logic
//   evt_count                     accepted events, saturating
//   spurious_count                irqs with empty edge capture, saturating
//   init_done                     mask/clear writes completed
module pio_irq_servicer
   import pio_irq_pkg::*;
#(
   parameter logic [31:0] INIT_MASK = 32'd1,
   parameter int unsigned CNT_W     = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   output logic [ADDR_W-1:0]  avm_address,
   output logic               avm_chipselect,
   output logic               avm_write_n,
   output logic [DATA_W-1:0]  avm_writedata,
   input  logic [DATA_W-1:0]  avm_readdata,
   input  logic               irq,
   output logic               evt_valid,
   input  logic               evt_ready,
   output logic               evt_level,
   output logic [CNT_W-1:0]   evt_count,
   output logic [SPUR_W-1:0]  spurious_count,
   output logic               init_done
);

   state_t              r_state;
   state_t              w_state_nxt;

   logic [ADDR_W-1:0]   r_addr;
   logic                r_cs;
   logic                r_write_n;
   logic [DATA_W-1:0]   r_wdata;
   logic                r_valid;
   logic                r_level;
   logic [CNT_W-1:0]    r_evt_count;
   logic [SPUR_W-1:0]   r_spur_count;
   logic                r_init_done;

   logic [ADDR_W-1:0]   w_addr_nxt;
   logic                w_cs_nxt;
   logic                w_write_n_nxt;
   logic [DATA_W-1:0]   w_wdata_nxt;
   logic                w_valid_nxt;
   logic                w_level_nxt;
   logic                w_init_done_nxt;
   logic                w_evt_inc;
   logic                w_spur_inc;

   // Only bit 0 of the PIO carries information for a 1-bit port.
   logic                w_unused_rdata;
   assign w_unused_rdata = ^avm_readdata[DATA_W-1:1];

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_INIT_MASK;
      else          r_state <= w_state_nxt;
   end

   // Next state and next registered outputs. The bus action decided here is
   // on the bus during the cycle the FSM spends in the next state, so a read
   // issued while entering X_RD is sampled while sitting in X_RD_W.
   always_comb begin
      w_state_nxt     = r_state;
      w_addr_nxt      = r_addr;
      w_cs_nxt        = 1'b0;
      w_write_n_nxt   = 1'b1;
      w_wdata_nxt     = '0;
      w_valid_nxt     = r_valid;
      w_level_nxt     = r_level;
      w_init_done_nxt = r_init_done;
      w_evt_inc       = 1'b0;
      w_spur_inc      = 1'b0;

      case (r_state)
         ST_INIT_MASK: begin
            w_cs_nxt      = 1'b1;
            w_write_n_nxt = 1'b0;
            w_addr_nxt    = PIO_MASK;
            w_wdata_nxt   = INIT_MASK;
            w_state_nxt   = ST_INIT_CLR;
         end
         ST_INIT_CLR: begin
            w_cs_nxt      = 1'b1;
            w_write_n_nxt = 1'b0;
            w_addr_nxt    = PIO_EDGE;
            w_state_nxt   = ST_IDLE;
         end
         ST_IDLE: begin
            // First IDLE cycle has the clearing write still on the bus;
            // irq only becomes meaningful once that write has landed.
            if (!r_init_done) begin
               w_init_done_nxt = 1'b1;
            end else if (irq) begin
               w_cs_nxt    = 1'b1;
               w_addr_nxt  = PIO_EDGE;
               w_state_nxt = ST_RD_EDGE;
            end
         end
         ST_RD_EDGE: begin
            w_state_nxt = ST_RD_EDGE_W;
         end
         ST_RD_EDGE_W: begin
            if (avm_readdata[0]) begin
               w_cs_nxt      = 1'b1;
               w_write_n_nxt = 1'b0;
               w_addr_nxt    = PIO_EDGE;
               w_state_nxt   = ST_CLR_EDGE;
            end else begin
               w_spur_inc  = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         ST_CLR_EDGE: begin
            w_cs_nxt    = 1'b1;
            w_addr_nxt  = PIO_DATA;
            w_state_nxt = ST_RD_LVL;
         end
         ST_RD_LVL: begin
            w_state_nxt = ST_RD_LVL_W;
         end
         ST_RD_LVL_W: begin
            w_level_nxt = avm_readdata[0];
            w_valid_nxt = 1'b1;
            w_state_nxt = ST_EMIT;
         end
         ST_EMIT: begin
            if (r_valid && evt_ready) begin
               w_valid_nxt = 1'b0;
               w_evt_inc   = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_INIT_MASK;
         end
      endcase
   end

   // Registered outputs and saturating counters.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_addr       <= '0;
         r_cs         <= 1'b0;
         r_write_n    <= 1'b1;
         r_wdata      <= '0;
         r_valid      <= 1'b0;
         r_level      <= 1'b0;
         r_evt_count  <= '0;
         r_spur_count <= '0;
         r_init_done  <= 1'b0;
      end else begin
         r_addr      <= w_addr_nxt;
         r_cs        <= w_cs_nxt;
         r_write_n   <= w_write_n_nxt;
         r_wdata     <= w_wdata_nxt;
         r_valid     <= w_valid_nxt;
         r_level     <= w_level_nxt;
         r_init_done <= w_init_done_nxt;
         if (w_evt_inc && (r_evt_count != {CNT_W{1'b1}}))
            r_evt_count <= r_evt_count + CNT_W'(1);
         if (w_spur_inc && (r_spur_count != {SPUR_W{1'b1}}))
            r_spur_count <= r_spur_count + SPUR_W'(1);
      end
   end

   assign avm_address    = r_addr;
   assign avm_chipselect = r_cs;
   assign avm_write_n    = r_write_n;
   assign avm_writedata  = r_wdata;
   assign evt_valid      = r_valid;
   assign evt_level      = r_level;
   assign evt_count      = r_evt_count;
   assign spurious_count = r_spur_count;
   assign init_done      = r_init_done;

endmodule

// File: tb/tb_pio_irq_servicer.sv
// Bench for pio_irq_servicer: two DUTs (16-bit and 3-bit event counters)
// each attached to its own PIO model, driven by shared pin/ready/irq stimulus.
module tb_pio_irq_servicer;

   localparam int unsigned N = 2;

   logic clk = 1'b0;
   logic reset_n;
   logic pin;
   logic ready;
   logic irq_force;

   always #5 clk = ~clk;

   logic [N-1:0]       v_cs, v_wn, v_valid, v_level, v_idone, v_pirq, v_mask;
   logic [N-1:0][1:0]  v_addr;
   logic [N-1:0][31:0] v_wdata;
   logic [N-1:0][15:0] v_cnt;
   logic [N-1:0][7:0]  v_spur;

   for (genvar g = 0; g < N; g++) begin : g_d
      localparam int unsigned CW = (g == 0) ? 16 : 3;
      logic [1:0]    addr;
      logic          cs, wn, irq, valid, level, idone;
      logic [31:0]   wdata, rdata;
      logic [CW-1:0] cnt;
      logic [7:0]    spur;
      logic          edge_cap, mask, prev;

      pio_irq_servicer #(.INIT_MASK(32'd1), .CNT_W(CW)) u_dut (
         .clk            (clk),
         .reset_n        (reset_n),
         .avm_address    (addr),
         .avm_chipselect (cs),
         .avm_write_n    (wn),
         .avm_writedata  (wdata),
         .avm_readdata   (rdata),
         .irq            (irq),
         .evt_valid      (valid),
         .evt_ready      (ready),
         .evt_level      (level),
         .evt_count      (cnt),
         .spurious_count (spur),
         .init_done      (idone)
      );

      // PIO model: rising-edge capture, any write to EDGE clears it,
      // read data registered (latency 1), junk with bit0=0 otherwise.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            edge_cap <= 1'b0;
            mask     <= 1'b0;
            prev     <= 1'b0;
            rdata    <= 32'hDEAD_BEEE;
         end else begin
            prev <= pin;
            if (cs && !wn && addr == 2'd3) edge_cap <= 1'b0;
            else if (pin && !prev)         edge_cap <= 1'b1;
            if (cs && !wn && addr == 2'd2) mask <= wdata[0];
            if (cs && wn) begin
               case (addr)
                  2'd0:    rdata <= {31'd0, pin};
                  2'd2:    rdata <= {31'd0, mask};
                  2'd3:    rdata <= {31'd0, edge_cap};
                  default: rdata <= 32'd0;
               endcase
            end else begin
               rdata <= 32'hDEAD_BEEE;
            end
         end
      end

      assign irq        = (edge_cap & mask) | irq_force;
      assign v_cs[g]    = cs;
      assign v_wn[g]    = wn;
      assign v_addr[g]  = addr;
      assign v_wdata[g] = wdata;
      assign v_valid[g] = valid;
      assign v_level[g] = level;
      assign v_idone[g] = idone;
      assign v_cnt[g]   = 16'(cnt);
      assign v_spur[g]  = spur;
      assign v_pirq[g]  = edge_cap & mask;
      assign v_mask[g]  = mask;
   end

   int errors = 0;
   int checks = 0;
   int n_acc  = 0;
   int n_spur = 0;

   typedef struct {
      logic        pin, rdy;
      logic        cs, wn;
      logic [1:0]  addr;
      logic [31:0] wd;
      logic        idone, pirq, vld, lvl;
      logic [15:0] cnt;
   } vec_t;

   vec_t tbl[13];

   function automatic vec_t row(logic p, logic r, logic c, logic w, logic [1:0] a,
                                logic [31:0] d, logic i, logic q, logic v, logic l,
                                logic [15:0] n);
      vec_t x;
      x.pin = p; x.rdy = r; x.cs = c; x.wn = w; x.addr = a; x.wd = d;
      x.idone = i; x.pirq = q; x.vld = v; x.lvl = l; x.cnt = n;
      return x;
   endfunction

   task automatic chk(input string nm, input int d, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h", nm, d, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int sat(input int n, input int maxv);
      return (n > maxv) ? maxv : n;
   endfunction

   task automatic chk_reset();
      for (int d = 0; d < N; d++) begin
         chk("rst_addr",  d, 32'(v_addr[d]),  32'd0);
         chk("rst_cs",    d, 32'(v_cs[d]),    32'd0);
         chk("rst_wn",    d, 32'(v_wn[d]),    32'd1);
         chk("rst_wdata", d, v_wdata[d],      32'd0);
         chk("rst_valid", d, 32'(v_valid[d]), 32'd0);
         chk("rst_level", d, 32'(v_level[d]), 32'd0);
         chk("rst_cnt",   d, 32'(v_cnt[d]),   32'd0);
         chk("rst_spur",  d, 32'(v_spur[d]),  32'd0);
         chk("rst_idone", d, 32'(v_idone[d]), 32'd0);
      end
   endtask

   task automatic chk_ev(input logic v, input logic l, input bit cl);
      for (int d = 0; d < N; d++) begin
         chk("evt_valid", d, 32'(v_valid[d]), 32'(v));
         if (cl) chk("evt_level", d, 32'(v_level[d]), 32'(l));
      end
   endtask

   task automatic chk_cnt();
      chk("evt_count", 0, 32'(v_cnt[0]), 32'(sat(n_acc, 65535)));
      chk("evt_count", 1, 32'(v_cnt[1]), 32'(sat(n_acc, 7)));
   endtask

   task automatic chk_spur(input int exp);
      for (int d = 0; d < N; d++) chk("spurious_count", d, 32'(v_spur[d]), 32'(exp));
   endtask

   task automatic run_table(input int nrows);
      for (int i = 0; i < nrows; i++) begin
         tick();
         pin   = tbl[i].pin;
         ready = tbl[i].rdy;
         for (int d = 0; d < N; d++) begin
            chk($sformatf("c%0d_cs", i+1),    d, 32'(v_cs[d]),    32'(tbl[i].cs));
            chk($sformatf("c%0d_wn", i+1),    d, 32'(v_wn[d]),    32'(tbl[i].wn));
            chk($sformatf("c%0d_addr", i+1),  d, 32'(v_addr[d]),  32'(tbl[i].addr));
            chk($sformatf("c%0d_wdata", i+1), d, v_wdata[d],      tbl[i].wd);
            chk($sformatf("c%0d_idone", i+1), d, 32'(v_idone[d]), 32'(tbl[i].idone));
            chk($sformatf("c%0d_pioirq", i+1),d, 32'(v_pirq[d]),  32'(tbl[i].pirq));
            chk($sformatf("c%0d_valid", i+1), d, 32'(v_valid[d]), 32'(tbl[i].vld));
            chk($sformatf("c%0d_level", i+1), d, 32'(v_level[d]), 32'(tbl[i].lvl));
         end
         chk($sformatf("c%0d_cnt", i+1), 0, 32'(v_cnt[0]), 32'(tbl[i].cnt));
         chk($sformatf("c%0d_cnt", i+1), 1, 32'(v_cnt[1]), 32'(sat(int'(tbl[i].cnt), 7)));
      end
   endtask

   // One episode from idle with pin low: a rising edge produces an event
   // 7 cycles after the pin change with level 1. If ready is low, the pin
   // follows pat for 'hold' cycles, then 'fin' with ready high; any rising
   // edge in that window must yield exactly one more event carrying 'fin'.
   task automatic ep(input bit r0, input int hold, input logic [31:0] pat, input bit fin);
      bit p, pend;
      pin   = 1'b1;
      ready = r0;
      for (int i = 1; i <= 6; i++) begin
         tick();
         chk_ev(1'b0, 1'b0, 1'b0);
      end
      tick();
      chk_ev(1'b1, 1'b1, 1'b1);
      if (r0) begin
         tick();
         n_acc++;
         chk_ev(1'b0, 1'b0, 1'b0);
         chk_cnt();
      end else begin
         p    = 1'b1;
         pend = 1'b0;
         for (int i = 0; i < hold; i++) begin
            pin = pat[i];
            if (pat[i] && !p) pend = 1'b1;
            p = pat[i];
            tick();
            chk_ev(1'b1, 1'b1, 1'b1);
         end
         pin = fin;
         if (fin && !p) pend = 1'b1;
         ready = 1'b1;
         tick();
         n_acc++;
         chk_ev(1'b0, 1'b0, 1'b0);
         chk_cnt();
         if (pend) begin
            for (int i = 0; i < 5; i++) begin
               tick();
               chk_ev(1'b0, 1'b0, 1'b0);
            end
            tick();
            chk_ev(1'b1, fin, 1'b1);
            tick();
            n_acc++;
            chk_ev(1'b0, 1'b0, 1'b0);
            chk_cnt();
         end
      end
      pin   = 1'b0;
      ready = 1'($urandom_range(0, 1));
      tick();
      tick();
      chk_ev(1'b0, 1'b0, 1'b0);
   endtask

   task automatic gap();
      int n;
      n = $urandom_range(0, 4);
      for (int i = 0; i < n; i++) begin
         ready = 1'($urandom_range(0, 1));
         tick();
         chk_ev(1'b0, 1'b0, 1'b0);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      tbl[0]  = row(0,1, 1,0,2'd2,32'd1, 0,0,0,0,16'd0);
      tbl[1]  = row(0,1, 1,0,2'd3,32'd0, 0,0,0,0,16'd0);
      tbl[2]  = row(0,1, 0,1,2'd3,32'd0, 1,0,0,0,16'd0);
      tbl[3]  = row(0,1, 0,1,2'd3,32'd0, 1,0,0,0,16'd0);
      tbl[4]  = row(1,1, 0,1,2'd3,32'd0, 1,0,0,0,16'd0);
      tbl[5]  = row(1,1, 0,1,2'd3,32'd0, 1,1,0,0,16'd0);
      tbl[6]  = row(1,1, 1,1,2'd3,32'd0, 1,1,0,0,16'd0);
      tbl[7]  = row(1,1, 0,1,2'd3,32'd0, 1,1,0,0,16'd0);
      tbl[8]  = row(1,1, 1,0,2'd3,32'd0, 1,1,0,0,16'd0);
      tbl[9]  = row(1,1, 1,1,2'd0,32'd0, 1,0,0,0,16'd0);
      tbl[10] = row(1,1, 0,1,2'd0,32'd0, 1,0,0,0,16'd0);
      tbl[11] = row(1,1, 0,1,2'd0,32'd0, 1,0,1,1,16'd0);
      tbl[12] = row(1,1, 0,1,2'd0,32'd0, 1,0,0,1,16'd1);

      reset_n   = 1'b0;
      pin       = 1'b0;
      ready     = 1'b0;
      irq_force = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset();
      reset_n = 1'b1;

      // Init writes, first service with ready high, T+6 latency.
      run_table(13);
      for (int d = 0; d < N; d++) chk("pio_mask", d, 32'(v_mask[d]), 32'd1);
      n_acc = 1;
      pin   = 1'b0;
      ready = 1'b0;
      tick();
      tick();

      // Backpressure for 20 cycles with 3 extra edges, pin ends low.
      ep(1'b0, 20, 32'h0000_002A, 1'b0);

      // Single forced irq with empty capture.
      irq_force = 1'b1;
      tick();
      irq_force = 1'b0;
      for (int d = 0; d < N; d++) begin
         chk("spur_rd_cs",   d, 32'(v_cs[d]),   32'd1);
         chk("spur_rd_wn",   d, 32'(v_wn[d]),   32'd1);
         chk("spur_rd_addr", d, 32'(v_addr[d]), 32'd3);
      end
      tick();
      tick();
      n_spur = 1;
      chk_spur(n_spur);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk_ev(1'b0, 1'b0, 1'b0);
         for (int d = 0; d < N; d++) chk("spur_bus_idle", d, 32'(v_cs[d]), 32'd0);
      end

      // Randomized episodes.
      for (int e = 0; e < 25; e++) begin
         gap();
         ep(1'($urandom_range(0, 1)), $urandom_range(1, 20), $urandom,
            1'($urandom_range(0, 1)));
      end
      chk_spur(n_spur);

      // Continuous spurious irq: far more than 255 services.
      irq_force = 1'b1;
      repeat (800) tick();
      irq_force = 1'b0;
      repeat (5) tick();
      chk_spur(255);
      chk_ev(1'b0, 1'b0, 1'b0);
      chk_cnt();

      // Reset asserted while the edge-clear write is on the bus.
      pin   = 1'b1;
      ready = 1'b1;
      repeat (4) tick();
      for (int d = 0; d < N; d++) begin
         chk("clr_cs",   d, 32'(v_cs[d]),   32'd1);
         chk("clr_wn",   d, 32'(v_wn[d]),   32'd0);
         chk("clr_addr", d, 32'(v_addr[d]), 32'd3);
      end
      #1;
      reset_n = 1'b0;
      #1;
      chk_reset();
      pin   = 1'b0;
      ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset();
      reset_n = 1'b1;
      run_table(3);
      for (int d = 0; d < N; d++) chk("pio_mask_reinit", d, 32'(v_mask[d]), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
